bcd_tick_counter: RTL

Parametrised multi-digit BCD counter with a built-in clock-divider tick generator. It replaces the fixed 1 Hz / 0–59 display counter with configurable tick period, digit count and modulus. It adds up/down counting, pause, synchronous load with validity checking, and tick/wrap status pulses. It sits between the board clock and the hex-to-seven-segment converters, one digit per display.

---
 rtl/bcd_tick_counter_if.sv | 25 ++
 rtl/bcd_tick_counter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/bcd_tick_counter_if.sv
// Control and status bundle for bcd_tick_counter.
// master: drives enable/direction/load and observes the count and status pulses.
// slave:  the counter itself.
interface bcd_tick_counter_if #(
    parameter int unsigned NUM_DIGITS = 2
);
    logic                    ENABLE_I;
    logic                    UP_I;
    logic                    LOAD_I;
    logic [4*NUM_DIGITS-1:0] LOAD_VALUE_I;
    logic [4*NUM_DIGITS-1:0] BCD_O;
    logic                    TICK_O;
    logic                    WRAP_O;
    logic                    LOAD_ERR_O;

    modport master (
        output ENABLE_I, UP_I, LOAD_I, LOAD_VALUE_I,
        input  BCD_O, TICK_O, WRAP_O, LOAD_ERR_O
    );

    modport slave (
        input  ENABLE_I, UP_I, LOAD_I, LOAD_VALUE_I,
        output BCD_O, TICK_O, WRAP_O, LOAD_ERR_O
    );
endinterface

// File: rtl/bcd_tick_counter.sv
// Multi-digit BCD counter with an integrated clock-divider tick generator.
// Counts up or down modulo MOD_VALUE, one step every DIV_COUNT enabled cycles,
// with pause, validated synchronous load and tick/wrap/load-error pulses.
module bcd_tick_counter #(
    parameter int unsigned DIV_COUNT  = 50000000,
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned MOD_VALUE  = 60
) (
    input  logic CLOCK_50_I,
    input  logic RESET_I,
    bcd_tick_counter_if.slave bus
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned DIV_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);

    // Elaboration-time binary-to-BCD conversion for the wrap limit.
    function automatic logic [BCD_W-1:0] to_bcd(input int unsigned v);
        logic [BCD_W-1:0] r;
        int unsigned      t;
        r = '0;
        t = v;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    localparam logic [BCD_W-1:0] MAX_BCD = to_bcd(MOD_VALUE - 1);

    logic [DIV_W-1:0] div_q;
    logic [BCD_W-1:0] bcd_q;
    logic             tick_q;
    logic             wrap_q;
    logic             load_err_q;

    logic [BCD_W-1:0] bcd_inc;
    logic [BCD_W-1:0] bcd_dec;
    logic             carry;
    logic             borrow;
    logic [3:0]       digit;
    logic             load_digits_ok;
    logic             load_ok;
    logic             at_max;
    logic             at_zero;
    logic             div_last;

    // Ripple BCD increment/decrement of the current count and per-digit load check.
    always_comb begin
        bcd_inc        = bcd_q;
        bcd_dec        = bcd_q;
        carry          = 1'b1;
        borrow         = 1'b1;
        digit          = '0;
        load_digits_ok = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            digit = bcd_q[4*k +: 4];
            if (carry) begin
                if (digit == 4'd9) begin
                    bcd_inc[4*k +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*k +: 4] = digit + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (digit == 4'd0) begin
                    bcd_dec[4*k +: 4] = 4'd9;
                end else begin
                    bcd_dec[4*k +: 4] = digit - 4'd1;
                    borrow = 1'b0;
                end
            end
            if (bus.LOAD_VALUE_I[4*k +: 4] > 4'd9) begin
                load_digits_ok = 1'b0;
            end
        end
    end

    // With every digit <= 9, an unsigned compare of BCD words orders them numerically,
    // so the range check needs no binary conversion.
    always_comb begin
        load_ok  = load_digits_ok && (bus.LOAD_VALUE_I <= MAX_BCD);
        at_max   = (bcd_q == MAX_BCD);
        at_zero  = (bcd_q == '0);
        div_last = (div_q == DIV_LAST);
    end

    // Divider, count and status pulses; priority reset > load > step.
    always_ff @(posedge CLOCK_50_I) begin
        if (RESET_I) begin
            div_q      <= '0;
            bcd_q      <= '0;
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
            if (bus.LOAD_I) begin
                if (load_ok) begin
                    bcd_q <= bus.LOAD_VALUE_I;
                    div_q <= '0;
                end else begin
                    load_err_q <= 1'b1;
                end
            end else if (bus.ENABLE_I) begin
                if (div_last) begin
                    div_q  <= '0;
                    tick_q <= 1'b1;
                    if (bus.UP_I) begin
                        if (at_max) begin
                            bcd_q  <= '0;
                            wrap_q <= 1'b1;
                        end else begin
                            bcd_q <= bcd_inc;
                        end
                    end else begin
                        if (at_zero) begin
                            bcd_q  <= MAX_BCD;
                            wrap_q <= 1'b1;
                        end else begin
                            bcd_q <= bcd_dec;
                        end
                    end
                end else begin
                    div_q <= div_q + DIV_W'(1);
                end
            end
        end
    end

    assign bus.BCD_O      = bcd_q;
    assign bus.TICK_O     = tick_q;
    assign bus.WRAP_O     = wrap_q;
    assign bus.LOAD_ERR_O = load_err_q;

endmodule
